// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the bouncing-logo block.
//  - dir_e / axis_t : per-axis motion direction and the result of one motion step
//  - LOGO_ROWS      : 22x9 "TT08" glyph bitmap, bit 0 = leftmost column
//  - PALETTE        : eight RGB222 colours stepped on every wall hit, entry 0 is white
//  - axis_step      : one motion step of a single axis with clamping at both walls
package gfx_pkg;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    typedef struct packed {
        logic [10:0] pos;
        dir_e        dir;
        logic        hit;
    } axis_t;

    localparam int GLYPH_W = 22;
    localparam int GLYPH_H = 9;

    localparam logic [GLYPH_W-1:0] LOGO_ROWS [0:GLYPH_H-1] = '{
        22'h0633DE,
        22'h09498C,
        22'h09498C,
        22'h06498C,
        22'h09498C,
        22'h09498C,
        22'h06318C,
        22'h000000,
        22'h000000
    };

    localparam logic [5:0] PALETTE [0:7] = '{
        6'h3F, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h0F, 6'h33, 6'h2A
    };

    // The subtract side compares pos <= step first, so the 11-bit result never wraps.
    function automatic axis_t axis_step(input logic [10:0] pos, input dir_e dir,
                                        input logic [10:0] step, input logic [10:0] lim);
        axis_t res;
        res.pos = pos;
        res.dir = dir;
        res.hit = 1'b0;
        case (dir)
            DIR_POS: begin
                if ((pos + step) >= lim) begin
                    res.pos = lim;
                    res.dir = DIR_NEG;
                    res.hit = 1'b1;
                end else begin
                    res.pos = pos + step;
                end
            end
            DIR_NEG: begin
                if (pos <= step) begin
                    res.pos = 11'd0;
                    res.dir = DIR_POS;
                    res.hit = 1'b1;
                end else begin
                    res.pos = pos - step;
                end
            end
            default: begin
                res.pos = pos;
                res.dir = DIR_POS;
                res.hit = 1'b0;
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/logo_rom.sv
// Combinational logo bitmap lookup.
//  row  : source-pixel row index (11 bits, may lie beyond the bitmap)
//  bits : LOGO_W-bit row vector, bit 0 = leftmost column; zero for row >= LOGO_H
module logo_rom
    import gfx_pkg::*;
#(
    parameter int LOGO_W = 22,
    parameter int LOGO_H = 9
) (
    input  logic [10:0]       row,
    output logic [LOGO_W-1:0] bits
);

    // Row select; anything outside the bitmap reads as background.
    always_comb begin
        if (row < 11'(LOGO_H)) begin
            case (row)
                11'd0:   bits = LOGO_W'(LOGO_ROWS[0]);
                11'd1:   bits = LOGO_W'(LOGO_ROWS[1]);
                11'd2:   bits = LOGO_W'(LOGO_ROWS[2]);
                11'd3:   bits = LOGO_W'(LOGO_ROWS[3]);
                11'd4:   bits = LOGO_W'(LOGO_ROWS[4]);
                11'd5:   bits = LOGO_W'(LOGO_ROWS[5]);
                11'd6:   bits = LOGO_W'(LOGO_ROWS[6]);
                11'd7:   bits = LOGO_W'(LOGO_ROWS[7]);
                11'd8:   bits = LOGO_W'(LOGO_ROWS[8]);
                default: bits = {LOGO_W{1'b0}};
            endcase
        end else begin
            bits = {LOGO_W{1'b0}};
        end
    end

endmodule

// File: rtl/logo_bounce_engine.sv
// Bouncing up-scaled logo renderer between the VGA timing generator and RGB222 pins.
//  clk, rst_n            : pixel clock, asynchronous active-low reset
//  x, y, frame_active    : current pixel coordinate and visible-area flag
//  frame_tick            : one pulse per frame in vertical blanking, advances motion
//  move_en               : 1 = logo moves on frame_tick, 0 = frozen
//  r, g, b               : registered colour outputs, 1-cycle latency from x/y
//  bounce                : one-cycle pulse on the cycle after any wall hit
module logo_bounce_engine
    import gfx_pkg::*;
#(
    parameter int LOGO_W     = 22,
    parameter int LOGO_H     = 9,
    parameter int SCALE_LOG2 = 2,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int STEP       = 1,
    parameter int INIT_X     = 32,
    parameter int INIT_Y     = 40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       frame_active,
    input  logic       frame_tick,
    input  logic       move_en,
    output logic [1:0] r,
    output logic [1:0] g,
    output logic [1:0] b,
    output logic       bounce
);

    localparam logic [10:0] SW       = 11'(LOGO_W << SCALE_LOG2);
    localparam logic [10:0] SH       = 11'(LOGO_H << SCALE_LOG2);
    localparam logic [10:0] XMAX     = 11'(H_ACTIVE - (LOGO_W << SCALE_LOG2));
    localparam logic [10:0] YMAX     = 11'(V_ACTIVE - (LOGO_H << SCALE_LOG2));
    localparam logic [10:0] STEP_V   = 11'(STEP);
    localparam logic [10:0] INIT_X_V = 11'(INIT_X);
    localparam logic [10:0] INIT_Y_V = 11'(INIT_Y);

    logic [10:0]       pos_x_r, pos_y_r;
    dir_e              dir_x_r, dir_y_r;
    logic [2:0]        col_idx_r;
    logic [5:0]        rgb_r;
    logic              bounce_r;

    axis_t             ax_s, ay_s;
    logic [10:0]       pos_x_nxt_s, pos_y_nxt_s;
    dir_e              dir_x_nxt_s, dir_y_nxt_s;
    logic [2:0]        col_idx_nxt_s;
    logic              wall_s;

    logic [10:0]       rel_x_s, rel_y_s, col_s, row_s;
    logic              in_box_s, pix_bit_s;
    logic [LOGO_W-1:0] row_bits_s;
    logic [5:0]        rgb_nxt_s;

    logo_rom #(
        .LOGO_W (LOGO_W),
        .LOGO_H (LOGO_H)
    ) u_rom (
        .row  (row_s),
        .bits (row_bits_s)
    );

    // Motion next-state: both axes step on an enabled tick, any wall hit advances the colour once.
    always_comb begin
        ax_s          = axis_step(pos_x_r, dir_x_r, STEP_V, XMAX);
        ay_s          = axis_step(pos_y_r, dir_y_r, STEP_V, YMAX);
        pos_x_nxt_s   = pos_x_r;
        pos_y_nxt_s   = pos_y_r;
        dir_x_nxt_s   = dir_x_r;
        dir_y_nxt_s   = dir_y_r;
        col_idx_nxt_s = col_idx_r;
        wall_s        = 1'b0;
        if (frame_tick && move_en) begin
            pos_x_nxt_s = ax_s.pos;
            pos_y_nxt_s = ay_s.pos;
            dir_x_nxt_s = ax_s.dir;
            dir_y_nxt_s = ay_s.dir;
            wall_s      = ax_s.hit | ay_s.hit;
            if (wall_s) begin
                col_idx_nxt_s = col_idx_r + 3'd1;
            end else begin
                col_idx_nxt_s = col_idx_r;
            end
        end else begin
            wall_s = 1'b0;
        end
    end

    // Pixel address: offsets are 11 bits so x < pos wraps high and fails the < SW test.
    always_comb begin
        rel_x_s = {1'b0, x} - pos_x_r;
        rel_y_s = {1'b0, y} - pos_y_r;
        col_s   = rel_x_s >> SCALE_LOG2;
        row_s   = rel_y_s >> SCALE_LOG2;
    end

    // Pixel colour: bitmap bit inside the logo box, black everywhere else.
    always_comb begin
        in_box_s = frame_active && ({1'b0, x} >= pos_x_r) && (rel_x_s < SW)
                                && ({1'b0, y} >= pos_y_r) && (rel_y_s < SH);
        pix_bit_s = 1'b0;
        for (int i = 0; i < LOGO_W; i++) begin
            if (col_s == 11'(i)) begin
                pix_bit_s = row_bits_s[i];
            end else begin
                pix_bit_s = pix_bit_s;
            end
        end
        if (in_box_s && pix_bit_s) begin
            rgb_nxt_s = PALETTE[col_idx_r];
        end else begin
            rgb_nxt_s = 6'h00;
        end
    end

    // Motion and palette state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_r   <= INIT_X_V;
            pos_y_r   <= INIT_Y_V;
            dir_x_r   <= DIR_POS;
            dir_y_r   <= DIR_POS;
            col_idx_r <= 3'd0;
        end else begin
            pos_x_r   <= pos_x_nxt_s;
            pos_y_r   <= pos_y_nxt_s;
            dir_x_r   <= dir_x_nxt_s;
            dir_y_r   <= dir_y_nxt_s;
            col_idx_r <= col_idx_nxt_s;
        end
    end

    // Registered colour and bounce outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r    <= 6'h00;
            bounce_r <= 1'b0;
        end else begin
            rgb_r    <= rgb_nxt_s;
            bounce_r <= wall_s;
        end
    end

    assign r      = rgb_r[5:4];
    assign g      = rgb_r[3:2];
    assign b      = rgb_r[1:0];
    assign bounce = bounce_r;

endmodule

// File: tb/tb_logo_bounce_engine.sv
// Randomized self-checking bench for logo_bounce_engine.
// Three instances share the stimulus: default parameters, a right-wall start
// (INIT_X=548, STEP=2) and a tiny playfield (XMAX=12, YMAX=13, STEP=3) that
// bounces every few ticks, including corner hits and palette wrap.
module tb_logo_bounce_engine;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       frame_active, frame_tick, move_en;
    logic [1:0] rr [3];
    logic [1:0] gg [3];
    logic [1:0] bb [3];
    logic       bn [3];

    always #5 clk = ~clk;

    logo_bounce_engine u_def (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_active(frame_active),
        .frame_tick(frame_tick), .move_en(move_en),
        .r(rr[0]), .g(gg[0]), .b(bb[0]), .bounce(bn[0])
    );

    logo_bounce_engine #(.INIT_X(548), .STEP(2)) u_edge (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_active(frame_active),
        .frame_tick(frame_tick), .move_en(move_en),
        .r(rr[1]), .g(gg[1]), .b(bb[1]), .bounce(bn[1])
    );

    logo_bounce_engine #(.H_ACTIVE(100), .V_ACTIVE(49), .STEP(3), .INIT_X(8), .INIT_Y(8)) u_small (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_active(frame_active),
        .frame_tick(frame_tick), .move_en(move_en),
        .r(rr[2]), .g(gg[2]), .b(bb[2]), .bounce(bn[2])
    );

    // Reference picture of the "TT08" logo, column 0 on the left.
    string art [9] = '{
        ".####.####..##...##...",
        "..##...##..#..#.#..#..",
        "..##...##..#..#.#..#..",
        "..##...##..#..#..##...",
        "..##...##..#..#.#..#..",
        "..##...##..#..#.#..#..",
        "..##...##...##...##...",
        "......................",
        "......................"
    };
    logic [5:0] pal [8] = '{6'h3F, 6'h30, 6'h0C, 6'h03, 6'h3C, 6'h0F, 6'h33, 6'h2A};

    // Per-instance reference state and configuration.
    int ix [3] = '{32, 548, 8};
    int iy [3] = '{40, 40, 8};
    int st [3] = '{1, 2, 3};
    int xm [3] = '{552, 552, 12};
    int ym [3] = '{444, 444, 13};
    int mx [3], my [3], vx [3], vy [3], ci [3];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mx[k] = ix[k]; my[k] = iy[k];
            vx[k] = 1;     vy[k] = 1;
            ci[k] = 0;
        end
    endtask

    // One axis moves by dir*step, clamping at 0 or at the far wall and turning around.
    task automatic move_axis(inout int p, inout int d, input int s, input int lim, output bit hit);
        int n;
        n   = p + d * s;
        hit = 1'b0;
        if (d > 0 && n >= lim) begin
            p = lim; d = -1; hit = 1'b1;
        end else if (d < 0 && n <= 0) begin
            p = 0; d = 1; hit = 1'b1;
        end else begin
            p = n;
        end
    endtask

    function automatic logic [5:0] exp_pix(int k, int xx, int yy, bit fa);
        int rx, ry;
        rx = xx - mx[k];
        ry = yy - my[k];
        if (!fa || rx < 0 || ry < 0 || rx >= 88 || ry >= 36) return 6'h00;
        if (art[ry / 4].getc(rx / 4) == 8'h23) return pal[ci[k]];
        return 6'h00;
    endfunction

    // Drive one cycle of inputs, predict each instance, then check after the edge.
    task automatic step_cycle(input int xx, input int yy, input bit fa, input bit tk, input bit men);
        logic [5:0] e_rgb [3];
        bit         e_bn  [3];
        bit         hx, hy;
        x = 10'(xx); y = 10'(yy);
        frame_active = fa; frame_tick = tk; move_en = men;
        for (int k = 0; k < 3; k++) begin
            e_rgb[k] = exp_pix(k, xx, yy, fa);
            e_bn[k]  = 1'b0;
            if (tk && men) begin
                move_axis(mx[k], vx[k], st[k], xm[k], hx);
                move_axis(my[k], vy[k], st[k], ym[k], hy);
                e_bn[k] = hx | hy;
                if (hx | hy) ci[k] = (ci[k] + 1) % 8;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rgb%0d", k), {2'b00, rr[k], gg[k], bb[k]}, {2'b00, e_rgb[k]});
            check_eq($sformatf("bounce%0d", k), {7'd0, bn[k]}, {7'd0, e_bn[k]});
        end
    endtask

    task automatic random_phase(input int cycles);
        int k, xx, yy;
        for (int c = 0; c < cycles; c++) begin
            k = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) begin
                xx = int'($urandom_range(0, 1023));
                yy = int'($urandom_range(0, 1023));
            end else begin
                xx = mx[k] - 6 + int'($urandom_range(0, 100));
                yy = my[k] - 4 + int'($urandom_range(0, 44));
                if (xx < 0) xx = 0;
                if (yy < 0) yy = 0;
            end
            step_cycle(xx, yy, $urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x = 10'd0; y = 10'd0;
        frame_active = 1'b0; frame_tick = 1'b0; move_en = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("reset_rgb%0d", k), {2'b00, rr[k], gg[k], bb[k]}, 8'h00);
            check_eq($sformatf("reset_bounce%0d", k), {7'd0, bn[k]}, 8'h00);
        end
        rst_n = 1'b1;

        // Frozen logo at the default position: column 2 lit, column 0 dark, blanking dark.
        step_cycle(40, 40, 1'b1, 1'b0, 1'b0);
        check_eq("lit_col2", {2'b00, rr[0], gg[0], bb[0]}, 8'h3F);
        step_cycle(32, 40, 1'b1, 1'b0, 1'b0);
        check_eq("dark_col0", {2'b00, rr[0], gg[0], bb[0]}, 8'h00);
        step_cycle(40, 40, 1'b0, 1'b0, 1'b0);
        check_eq("blank_col2", {2'b00, rr[0], gg[0], bb[0]}, 8'h00);
        step_cycle(40, 40, 1'b1, 1'b1, 1'b0);

        // Right wall with STEP=2: 550, 552 (bounce), 550, watched on the edge instance.
        for (int t = 0; t < 3; t++) begin
            step_cycle(554, 40 + 2 * t, 1'b1, 1'b1, 1'b1);
            if (t == 1) check_eq("edge_bounce", {7'd0, bn[1]}, 8'h01);
            step_cycle(554, 42 + 2 * t, 1'b1, 1'b0, 1'b1);
        end
        step_cycle(554, 46, 1'b1, 1'b0, 1'b0);
        check_eq("edge_back_550", {2'b00, rr[1], gg[1], bb[1]}, 8'h30);

        random_phase(2000);

        // Reset while the default instance is drawing a lit pixel.
        step_cycle(mx[0] + 4, my[0], 1'b1, 1'b0, 1'b0);
        check_eq("pre_reset_lit", {2'b00, rr[0], gg[0], bb[0]}, {2'b00, pal[ci[0]]});
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("async_rst_rgb%0d", k), {2'b00, rr[k], gg[k], bb[k]}, 8'h00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step_cycle(40, 40, 1'b1, 1'b0, 1'b0);
        check_eq("post_reset_lit", {2'b00, rr[0], gg[0], bb[0]}, 8'h3F);

        random_phase(2000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
